ring_pair_eval: RTL and testbench

- Measurement sequencer for the ring-oscillator counting path. It drives the counting circuits and reads back their results.
- For each ring-oscillator pair, in order:
  - enables the pair's rings;
  - clears and gates two 16-bit counting circuits (A and B) for a fixed window;
  - reads both counts and compares them, producing one response bit.
- When all pairs are done, the response word is presented with a one-cycle valid strobe.

---
 rtl/ring_pair_eval.sv | 188 ++++++++++++++++++
 tb/tb_ring_pair_eval.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_pair_eval.sv
// Ring-oscillator pair measurement sequencer: gates two counters per pair and packs the A>B results into a response word.
// Optional build macro RING_MARGIN_EN adds the MARGIN parameter and the per-pair 'unstable' output.
module ring_pair_eval #(
    parameter int NUM_PAIRS = 8,
    parameter int WINDOW    = 1000,
    parameter int SETTLE    = 4,
`ifdef RING_MARGIN_EN
    parameter int MARGIN    = 8,
`endif
    parameter int PSEL_W    = $clog2(NUM_PAIRS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic [PSEL_W-1:0]    pair_sel,
    output logic                 ring_en,
    output logic                 cnt_clear,
    output logic                 cnt_gate,
    input  logic [15:0]          count_a,
    input  logic [15:0]          count_b,
    output logic [NUM_PAIRS-1:0] resp,
    output logic                 resp_valid,
`ifdef RING_MARGIN_EN
    output logic [NUM_PAIRS-1:0] unstable,
`endif
    output logic                 sat_flag
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SETTLE, S_GATE, S_HOLD, S_COMPARE, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [PSEL_W-1:0]     psel_q, psel_d;
    logic [NUM_PAIRS-1:0]  resp_q, resp_d;
    logic                  sat_q, sat_d;
    logic                  busy_q, busy_d;
    logic                  ring_en_q, ring_en_d;
    logic                  clr_q, clr_d;
    logic                  gate_q, gate_d;
    logic                  valid_q, valid_d;
`ifdef RING_MARGIN_EN
    logic [NUM_PAIRS-1:0]  unst_q, unst_d;
    logic [16:0]           abs_diff;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        timer_d   = timer_q;
        psel_d    = psel_q;
        resp_d    = resp_q;
        sat_d     = sat_q;
        busy_d    = 1'b0;
        ring_en_d = 1'b0;
        clr_d     = 1'b0;
        gate_d    = 1'b0;
        valid_d   = 1'b0;
`ifdef RING_MARGIN_EN
        unst_d    = unst_q;
        abs_diff  = (count_a >= count_b) ? ({1'b0, count_a} - {1'b0, count_b})
                                         : ({1'b0, count_b} - {1'b0, count_a});
`endif
        // Strobes are decoded from the current state and registered, so pins lag the state by one cycle.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    resp_d  = '0;
                    sat_d   = 1'b0;
                    psel_d  = '0;
`ifdef RING_MARGIN_EN
                    unst_d  = '0;
`endif
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy_d    = 1'b1;
                ring_en_d = 1'b1;
                clr_d     = 1'b1;
                timer_d   = TW'(SETTLE - 1);
                state_d   = S_SETTLE;
            end
            S_SETTLE: begin
                busy_d    = 1'b1;
                ring_en_d = 1'b1;
                if (timer_q == '0) begin
                    timer_d = TW'(WINDOW - 1);
                    state_d = S_GATE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_GATE: begin
                busy_d    = 1'b1;
                ring_en_d = 1'b1;
                gate_d    = 1'b1;
                if (timer_q == '0) begin
                    timer_d = TW'(1);
                    state_d = S_HOLD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_HOLD: begin
                busy_d = 1'b1;
                if (timer_q == '0) begin
                    state_d = S_COMPARE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_COMPARE: begin
                busy_d         = 1'b1;
                resp_d[psel_q] = (count_a > count_b);
                if ((count_a == 16'hFFFF) || (count_b == 16'hFFFF)) begin
                    sat_d = 1'b1;
                end
`ifdef RING_MARGIN_EN
                unst_d[psel_q] = (abs_diff < 17'(MARGIN));
`endif
                if (psel_q == PSEL_W'(NUM_PAIRS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    psel_d  = psel_q + PSEL_W'(1);
                    state_d = S_CLEAR;
                end
            end
            S_DONE: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            psel_q    <= '0;
            resp_q    <= '0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b0;
            ring_en_q <= 1'b0;
            clr_q     <= 1'b0;
            gate_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef RING_MARGIN_EN
            unst_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            psel_q    <= psel_d;
            resp_q    <= resp_d;
            sat_q     <= sat_d;
            busy_q    <= busy_d;
            ring_en_q <= ring_en_d;
            clr_q     <= clr_d;
            gate_q    <= gate_d;
            valid_q   <= valid_d;
`ifdef RING_MARGIN_EN
            unst_q    <= unst_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign pair_sel   = psel_q;
    assign ring_en    = ring_en_q;
    assign cnt_clear  = clr_q;
    assign cnt_gate   = gate_q;
    assign resp       = resp_q;
    assign resp_valid = valid_q;
    assign sat_flag   = sat_q;
`ifdef RING_MARGIN_EN
    assign unstable   = unst_q;
`endif

endmodule

// File: tb/tb_ring_pair_eval.sv
// Self-checking bench for ring_pair_eval (NUM_PAIRS=4, WINDOW=16, SETTLE=2); a timeline model predicts every output each cycle.
module tb_ring_pair_eval;

    localparam int NP   = 4;
    localparam int WIN  = 16;
    localparam int SET  = 2;
    localparam int PER  = WIN + SET + 4;
    localparam int LAST = 1 + NP * PER;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic [1:0]  pair_sel;
    logic        ring_en;
    logic        cnt_clear;
    logic        cnt_gate;
    logic [15:0] count_a;
    logic [15:0] count_b;
    logic [3:0]  resp;
    logic        resp_valid;
    logic        sat_flag;
`ifdef RING_MARGIN_EN
    logic [3:0]  unstable;
`endif

    logic [15:0] ca [NP];
    logic [15:0] cb [NP];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    ring_pair_eval #(.NUM_PAIRS(NP), .WINDOW(WIN), .SETTLE(SET)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .pair_sel   (pair_sel),
        .ring_en    (ring_en),
        .cnt_clear  (cnt_clear),
        .cnt_gate   (cnt_gate),
        .count_a    (count_a),
        .count_b    (count_b),
        .resp       (resp),
        .resp_valid (resp_valid),
`ifdef RING_MARGIN_EN
        .unstable   (unstable),
`endif
        .sat_flag   (sat_flag)
    );

    // The counting circuits, as seen through the pair mux.
    assign count_a = ca[pair_sel];
    assign count_b = cb[pair_sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: edges since the accepting edge, with compare results taken from the bench's own count table.
    int          m_t    = 0;
    bit          m_run  = 1'b0;
    logic [NP-1:0] m_resp = '0;
    logic [NP-1:0] m_unst = '0;
    logic        m_sat  = 1'b0;
    int          m_psel = 0;
    int          m_p;
    int          m_d;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_t = 0; m_resp = '0; m_unst = '0; m_sat = 1'b0; m_psel = 0;
        end else if ((!m_run || m_t >= LAST) && start) begin
            m_run = 1'b1; m_t = 0; m_resp = '0; m_unst = '0; m_sat = 1'b0; m_psel = 0;
        end else if (m_run && m_t < 1000) begin
            m_t++;
            if (m_t % PER == 0 && m_t / PER <= NP) begin
                m_p = m_t / PER - 1;
                m_resp[m_p] = (ca[m_p] > cb[m_p]);
                if (ca[m_p] == 16'hFFFF || cb[m_p] == 16'hFFFF) m_sat = 1'b1;
                m_d = int'(ca[m_p]) - int'(cb[m_p]);
                if (m_d < 0) m_d = -m_d;
                m_unst[m_p] = (m_d < 8);
                if (m_p < NP - 1) m_psel = m_p + 1;
            end
        end
    end

    always @(negedge clk) begin
        bit in_pair;
        int ph;
        if (chk_en) begin
            in_pair = m_run && m_t >= 1 && m_t <= LAST - 1;
            ph      = (m_t - 1) % PER;
            check("busy",       32'(busy),       32'(m_run && m_t >= 1 && m_t <= LAST));
            check("resp_valid", 32'(resp_valid), 32'(m_run && m_t == LAST));
            check("ring_en",    32'(ring_en),    32'(in_pair && ph <= SET + WIN));
            check("cnt_clear",  32'(cnt_clear),  32'(in_pair && ph == 0));
            check("cnt_gate",   32'(cnt_gate),   32'(in_pair && ph >= SET + 1 && ph <= SET + WIN));
            check("pair_sel",   32'(pair_sel),   32'(m_psel));
            check("resp",       32'(resp),       32'(m_resp));
            check("sat_flag",   32'(sat_flag),   32'(m_sat));
`ifdef RING_MARGIN_EN
            check("unstable",   32'(unstable),   32'(m_unst));
`endif
        end
    end

    task automatic set_counts(input logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3);
        ca[0] = a0; cb[0] = b0; ca[1] = a1; cb[1] = b1;
        ca[2] = a2; cb[2] = b2; ca[3] = a3; cb[3] = b3;
    endtask

    // Pulses start, samples #1 after each edge until resp_valid (bounded), gathering waveform statistics.
    task automatic do_run(input int mid_start_at, output int lat, output int nclr, output int ngate,
                          output int maxg, output int nring, output logic [7:0] hist,
                          output logic busy_at_valid, output logic valid_after, output logic busy_after);
        int run = 0;
        int last_ps = -1;
        lat = 0; nclr = 0; ngate = 0; maxg = 0; nring = 0; hist = '0; busy_at_valid = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            start = (lat == mid_start_at);
            nclr  += int'(cnt_clear);
            ngate += int'(cnt_gate);
            nring += int'(ring_en);
            run   = cnt_gate ? run + 1 : 0;
            if (run > maxg) maxg = run;
            if (int'(pair_sel) != last_ps) begin
                hist    = {hist[5:0], pair_sel};
                last_ps = int'(pair_sel);
            end
            if (resp_valid) begin
                busy_at_valid = busy;
                break;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        valid_after = resp_valid;
        busy_after  = busy;
    endtask

    initial begin
        int lat, nclr, ngate, maxg, nring, nvalid;
        logic [7:0] hist;
        logic bav, va, ba;

        rst = 1'b1; start = 1'b0;
        set_counts(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", 32'(busy), 0);
        check("reset_resp", 32'(resp), 0);
        check("reset_psel", 32'(pair_sel), 0);

        // Basic run and waveform shape.
        set_counts(16'd20, 16'd10, 16'd10, 16'd20, 16'd15, 16'd15, 16'd300, 16'd299);
        do_run(0, lat, nclr, ngate, maxg, nring, hist, bav, va, ba);
        check("s1_latency", 32'(lat), 89);
        check("s1_resp", 32'(resp), 32'b1001);
        check("s1_sat", 32'(sat_flag), 0);
        check("s1_busy_at_valid", 32'(bav), 1);
        check("s1_valid_one_cycle", 32'(va), 0);
        check("s1_busy_falls", 32'(ba), 0);
        check("s2_clear_cycles", 32'(nclr), 4);
        check("s2_gate_cycles", 32'(ngate), 64);
        check("s2_gate_run", 32'(maxg), 16);
        check("s2_ring_en_cycles", 32'(nring), 76);
        check("s2_pair_sel_seq", 32'(hist), 32'h1B);

        // Saturation plus an ignored mid-run start.
        set_counts(16'd20, 16'd10, 16'd10, 16'd20, 16'hFFFF, 16'd5, 16'd300, 16'd299);
        do_run(40, lat, nclr, ngate, maxg, nring, hist, bav, va, ba);
        check("s3_latency", 32'(lat), 89);
        check("s3_sat", 32'(sat_flag), 1);
        check("s3_resp", 32'(resp), 32'b1101);
        repeat (10) @(negedge clk);
        check("s3_no_restart", 32'(busy), 0);
        set_counts(16'd20, 16'd10, 16'd10, 16'd20, 16'd15, 16'd15, 16'd300, 16'd299);
        do_run(0, lat, nclr, ngate, maxg, nring, hist, bav, va, ba);
        check("s3_sat_cleared", 32'(sat_flag), 0);

        // Reset during GATE of pair 1.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("s4_busy", 32'(busy), 0);
        check("s4_ring_en", 32'(ring_en), 0);
        check("s4_gate", 32'(cnt_gate), 0);
        check("s4_resp", 32'(resp), 0);
        check("s4_psel", 32'(pair_sel), 0);
        nvalid = 0;
        repeat (120) begin
            @(posedge clk); #1;
            nvalid += int'(resp_valid);
        end
        check("s4_no_valid", 32'(nvalid), 0);
        do_run(0, lat, nclr, ngate, maxg, nring, hist, bav, va, ba);
        check("s4_fresh_latency", 32'(lat), 89);
        check("s4_fresh_resp", 32'(resp), 32'b1001);

        // start and rst in the same cycle.
        @(negedge clk); start = 1'b1; rst = 1'b1;
        @(negedge clk); start = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        check("s5_busy", 32'(busy), 0);
        check("s5_ring_en", 32'(ring_en), 0);
        check("s5_resp", 32'(resp), 0);

        // Margin vectors.
        set_counts(16'd100, 16'd95, 16'd100, 16'd80, 16'd50, 16'd57, 16'd0, 16'd0);
        do_run(0, lat, nclr, ngate, maxg, nring, hist, bav, va, ba);
        check("s6_resp", 32'(resp), 32'b0011);
`ifdef RING_MARGIN_EN
        check("s6_unstable", 32'(unstable), 32'b1101);
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
